// File: rtl/dm_pkg.sv
// Shared encodings for the sized data memory: access sizes, FSM states and
// the wait-state counter width.
package dm_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam int CNT_W = 4;

    // Reserved size, odd halfword or non-word-aligned word is an error.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        logic bad;
        case (size_e'(size))
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = lane[0];
            SZ_WORD: bad = (lane != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dm_sized_if.sv
// Request/response bundle between the MEM stage (master) and the data memory (slave).
interface dm_sized_if #(
    parameter int ADDR_W = 10
);
    logic              req;
    logic              we;
    logic [1:0]        size;
    logic              sign_ext;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              ready;
    logic              rvalid;
    logic [31:0]       rdata;
    logic              err;

    modport master (
        output req, we, size, sign_ext, addr, wdata,
        input  ready, rvalid, rdata, err
    );

    modport slave (
        input  req, we, size, sign_ext, addr, wdata,
        output ready, rvalid, rdata, err
    );
endinterface

// File: rtl/dm_lane_align.sv
// Little-endian lane steering: byte enables and replicated write data for
// stores, lane extraction plus zero/sign extension for loads.
module dm_lane_align
    import dm_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    input  logic        sign_ext,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wword,
    output logic [31:0] ldata,
    output logic        misalign
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign misalign = is_misaligned(size, lane);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign be[gi] = !misalign &&
                            ((size == SZ_BYTE && lane == 2'(gi)) ||
                             (size == SZ_HALF && lane[1] == (gi >= 2)) ||
                             (size == SZ_WORD));
        end
    endgenerate

    // Replicating the store data lets the byte enables pick the lanes.
    always_comb begin
        case (size_e'(size))
            SZ_BYTE: wword = {4{wdata[7:0]}};
            SZ_HALF: wword = {2{wdata[15:0]}};
            default: wword = wdata;
        endcase
    end

    assign byte_sel = rword[{lane, 3'b000} +: 8];
    assign half_sel = lane[1] ? rword[31:16] : rword[15:0];

    always_comb begin
        ldata = 32'h0;
        if (!misalign) begin
            case (size_e'(size))
                SZ_BYTE: ldata = {{24{sign_ext & byte_sel[7]}}, byte_sel};
                SZ_HALF: ldata = {{16{sign_ext & half_sel[15]}}, half_sel};
                SZ_WORD: ldata = rword;
                default: ldata = 32'h0;
            endcase
        end
    end
endmodule

// File: rtl/dm_sized.sv
// Byte-addressable data memory with sized accesses, misalignment errors and
// a req/ready/rvalid handshake with LATENCY cycles from accept to response.
module dm_sized
    import dm_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    dm_sized_if.slave   bus
);
    localparam int DEPTH = 2 ** (ADDR_W - 2);

    logic [31:0] mem [DEPTH];

    state_e             state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               we_reg;
    logic [1:0]         size_reg;
    logic               sign_ext_reg;
    logic [ADDR_W-1:0]  addr_reg;
    logic [31:0]        wdata_reg;
    logic               ready_reg;
    logic               rvalid_reg;
    logic [31:0]        rdata_reg;
    logic               err_reg;

    logic               accept;
    logic               commit;
    logic               use_live;
    logic               cur_we;
    logic [1:0]         cur_size;
    logic               cur_sign_ext;
    logic [ADDR_W-1:0]  cur_addr;
    logic [31:0]        cur_wdata;
    logic [ADDR_W-3:0]  cur_idx;
    logic [31:0]        rword;
    logic [3:0]         be;
    logic [31:0]        wword;
    logic [31:0]        ldata;
    logic               misalign;

    assign accept = bus.req && ready_reg;

    // With LATENCY=1 the commit edge is the accepting edge, so the live
    // request feeds the datapath; otherwise the captured copy does.
    assign use_live     = (state_reg == ST_IDLE);
    assign cur_we       = use_live ? bus.we       : we_reg;
    assign cur_size     = use_live ? bus.size     : size_reg;
    assign cur_sign_ext = use_live ? bus.sign_ext : sign_ext_reg;
    assign cur_addr     = use_live ? bus.addr     : addr_reg;
    assign cur_wdata    = use_live ? bus.wdata    : wdata_reg;
    assign cur_idx      = cur_addr[ADDR_W-1:2];

    assign commit = rst_n && ((accept && (LATENCY == 1)) ||
                              (state_reg == ST_WAIT && cnt_reg == '0));

    // Combinational read: the load value must be ready on the commit edge.
    assign rword = mem[cur_idx];

    dm_lane_align u_align (
        .size     (cur_size),
        .lane     (cur_addr[1:0]),
        .sign_ext (cur_sign_ext),
        .wdata    (cur_wdata),
        .rword    (rword),
        .be       (be),
        .wword    (wword),
        .ldata    (ldata),
        .misalign (misalign)
    );

    always_ff @(posedge clk) begin
        if (commit && cur_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[cur_idx][i*8 +: 8] <= wword[i*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            we_reg       <= 1'b0;
            size_reg     <= 2'b00;
            sign_ext_reg <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= 32'h0;
            ready_reg    <= 1'b1;
            rvalid_reg   <= 1'b0;
            rdata_reg    <= 32'h0;
            err_reg      <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        we_reg       <= bus.we;
                        size_reg     <= bus.size;
                        sign_ext_reg <= bus.sign_ext;
                        addr_reg     <= bus.addr;
                        wdata_reg    <= bus.wdata;
                        ready_reg    <= 1'b0;
                        if (LATENCY == 1) begin
                            state_reg  <= ST_RESP;
                            rvalid_reg <= 1'b1;
                        end else begin
                            state_reg <= ST_WAIT;
                            cnt_reg   <= CNT_W'(LATENCY - 2);
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt_reg == '0) begin
                        state_reg  <= ST_RESP;
                        rvalid_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                ST_RESP: begin
                    state_reg  <= ST_IDLE;
                    ready_reg  <= 1'b1;
                    rvalid_reg <= 1'b0;
                end
                default: begin
                    state_reg  <= ST_IDLE;
                    ready_reg  <= 1'b1;
                    rvalid_reg <= 1'b0;
                end
            endcase
            // Stores and errors both report zero data.
            if (commit) begin
                err_reg   <= misalign;
                rdata_reg <= cur_we ? 32'h0 : ldata;
            end
        end
    end

    assign bus.ready  = ready_reg;
    assign bus.rvalid = rvalid_reg;
    assign bus.rdata  = rdata_reg;
    assign bus.err    = err_reg;
endmodule

// File: tb/tb_dm_sized.sv
// Bench for dm_sized: three instances (LATENCY 2, 1, 15) checked against a
// byte-array reference model with directed and randomized accesses.
module tb_dm_sized;
    localparam int AW = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        req_v    [3];
    logic        we_v     [3];
    logic [1:0]  size_v   [3];
    logic        sx_v     [3];
    logic [9:0]  addr_v   [3];
    logic [31:0] wdata_v  [3];
    logic        ready_v  [3];
    logic        rvalid_v [3];
    logic [31:0] rdata_v  [3];
    logic        err_v    [3];

    int n_cmp = 0;
    int n_bad = 0;

    bit [7:0] mem_m [3][1024];

    function automatic int lat_of(input int s);
        return (s == 0) ? 2 : ((s == 1) ? 1 : 15);
    endfunction

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dut
            dm_sized_if #(.ADDR_W(AW)) bus ();
            assign bus.req       = req_v[gi];
            assign bus.we        = we_v[gi];
            assign bus.size      = size_v[gi];
            assign bus.sign_ext  = sx_v[gi];
            assign bus.addr      = addr_v[gi];
            assign bus.wdata     = wdata_v[gi];
            assign ready_v[gi]   = bus.ready;
            assign rvalid_v[gi]  = bus.rvalid;
            assign rdata_v[gi]   = bus.rdata;
            assign err_v[gi]     = bus.err;
            dm_sized #(
                .ADDR_W  (AW),
                .LATENCY ((gi == 0) ? 2 : ((gi == 1) ? 1 : 15))
            ) u_dut (
                .clk   (clk),
                .rst_n (rst_n),
                .bus   (bus)
            );
        end
    endgenerate

    // Reference model: memory as a flat byte array, sizes as byte counts.
    function automatic void model_access(input int d, input bit w, input bit [1:0] sz,
                                         input bit sx, input int a, input bit [31:0] wd,
                                         output bit er, output bit [31:0] rd);
        int nb;
        bit [63:0] v;
        nb = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : (sz == 2'b10) ? 4 : 0;
        rd = 32'h0;
        er = (nb == 0) ? 1'b1 : ((a % nb) != 0);
        if (er) return;
        if (w) begin
            for (int b = 0; b < nb; b++) mem_m[d][a+b] = wd[8*b +: 8];
            return;
        end
        v = 64'h0;
        for (int b = 0; b < nb; b++) v[8*b +: 8] = mem_m[d][a+b];
        if (sx && nb < 4 && v[8*nb-1]) v = v | (~64'h0 << (8*nb));
        rd = v[31:0];
    endfunction

    // Issue one request and report what the DUT did; callers do the checking.
    task automatic do_txn(input int s, input bit w, input bit [1:0] sz, input bit sx,
                          input bit [9:0] a, input bit [31:0] wd,
                          output int lat, output bit [31:0] rd, output bit er,
                          output bit rdy_mid, output bit rdy_after);
        @(negedge clk);
        req_v[s] = 1'b1; we_v[s] = w; size_v[s] = sz; sx_v[s] = sx;
        addr_v[s] = a; wdata_v[s] = wd;
        @(posedge clk);
        #1;
        req_v[s] = 1'b0;
        we_v[s] = 1'($urandom); size_v[s] = 2'($urandom); sx_v[s] = 1'($urandom);
        addr_v[s] = 10'($urandom); wdata_v[s] = $urandom;
        lat = -1; rd = 32'h0; er = 1'b0; rdy_mid = 1'b1;
        for (int k = 1; k <= lat_of(s) + 4; k++) begin
            @(negedge clk);
            if (k == 1) rdy_mid = ready_v[s];
            if (rvalid_v[s]) begin
                lat = k; rd = rdata_v[s]; er = err_v[s];
                break;
            end
        end
        @(negedge clk);
        rdy_after = ready_v[s] && !rvalid_v[s];
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            n_cmp++; if (ready_v[s] !== 1'b1) begin n_bad++; $display("FAIL reset_ready[%0d]: got %b want 1", s, ready_v[s]); end
            n_cmp++; if (rvalid_v[s] !== 1'b0) begin n_bad++; $display("FAIL reset_rvalid[%0d]: got %b want 0", s, rvalid_v[s]); end
            n_cmp++; if (rdata_v[s] !== 32'h0) begin n_bad++; $display("FAIL reset_rdata[%0d]: got %h want 0", s, rdata_v[s]); end
            n_cmp++; if (err_v[s] !== 1'b0) begin n_bad++; $display("FAIL reset_err[%0d]: got %b want 0", s, err_v[s]); end
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (ready_v[0] !== 1'b1) begin n_bad++; $display("FAIL release_ready: got %b want 1", ready_v[0]); end
    endtask

    task automatic preload;
        bit er; bit [31:0] rd; int lat; bit rm, ra;
        for (int s = 0; s < 3; s++)
            for (int w = 0; w < 256; w++) begin
                model_access(s, 1'b1, 2'b10, 1'b0, w*4, 32'h0, er, rd);
                do_txn(s, 1'b1, 2'b10, 1'b0, 10'(w*4), 32'h0, lat, rd, er, rm, ra);
            end
    endtask

    task automatic test_first_txn;
        bit er, e_er; bit [31:0] rd, e_rd; int lat; bit rm, ra;
        model_access(0, 1'b0, 2'b10, 1'b0, 0, 32'h0, e_er, e_rd);
        do_txn(0, 1'b0, 2'b10, 1'b0, 10'h0, 32'h0, lat, rd, er, rm, ra);
        n_cmp++; if (rm !== 1'b0) begin n_bad++; $display("FAIL first_ready_busy: got %b want 0", rm); end
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL first_latency: got %0d want 2", lat); end
        n_cmp++; if (ra !== 1'b1) begin n_bad++; $display("FAIL first_back_idle: got %b want 1", ra); end
        n_cmp++; if (rd !== e_rd) begin n_bad++; $display("FAIL first_rdata: got %h want %h", rd, e_rd); end
    endtask

    task automatic test_word_byte;
        bit er, e_er; bit [31:0] rd, e_rd; int lat; bit rm, ra;
        model_access(0, 1'b1, 2'b10, 1'b0, 'h10, 32'hDEADBEEF, e_er, e_rd);
        do_txn(0, 1'b1, 2'b10, 1'b0, 10'h10, 32'hDEADBEEF, lat, rd, er, rm, ra);
        n_cmp++; if (er !== 1'b0 || rd !== 32'h0) begin n_bad++; $display("FAIL word_store: got err=%b rdata=%h want err=0 rdata=0", er, rd); end
        model_access(0, 1'b0, 2'b10, 1'b0, 'h10, 32'h0, e_er, e_rd);
        do_txn(0, 1'b0, 2'b10, 1'b0, 10'h10, 32'h0, lat, rd, er, rm, ra);
        n_cmp++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin n_bad++; $display("FAIL word_load: got %h err=%b want deadbeef err=0", rd, er); end
        model_access(0, 1'b1, 2'b00, 1'b0, 'h12, 32'hFFFFFF5A, e_er, e_rd);
        do_txn(0, 1'b1, 2'b00, 1'b0, 10'h12, 32'hFFFFFF5A, lat, rd, er, rm, ra);
        n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL byte_store_err: got %b want 0", er); end
        do_txn(0, 1'b0, 2'b10, 1'b0, 10'h10, 32'h0, lat, rd, er, rm, ra);
        n_cmp++; if (rd !== 32'hDE5ABEEF) begin n_bad++; $display("FAIL byte_merge: got %h want de5abeef", rd); end
    endtask

    task automatic test_sign_ext;
        bit er; bit [31:0] rd; int lat; bit rm, ra;
        do_txn(0, 1'b0, 2'b00, 1'b1, 10'h13, 32'h0, lat, rd, er, rm, ra);
        n_cmp++; if (rd !== 32'hFFFFFFDE) begin n_bad++; $display("FAIL byte_sx: got %h want ffffffde", rd); end
        do_txn(0, 1'b0, 2'b00, 1'b0, 10'h13, 32'h0, lat, rd, er, rm, ra);
        n_cmp++; if (rd !== 32'h000000DE) begin n_bad++; $display("FAIL byte_zx: got %h want 000000de", rd); end
        do_txn(0, 1'b0, 2'b01, 1'b1, 10'h10, 32'h0, lat, rd, er, rm, ra);
        n_cmp++; if (rd !== 32'hFFFFBEEF) begin n_bad++; $display("FAIL half_sx: got %h want ffffbeef", rd); end
        do_txn(0, 1'b0, 2'b01, 1'b0, 10'h12, 32'h0, lat, rd, er, rm, ra);
        n_cmp++; if (rd !== 32'h0000DE5A) begin n_bad++; $display("FAIL half_zx_hi: got %h want 0000de5a", rd); end
    endtask

    task automatic test_misalign;
        bit er; bit [31:0] rd; int lat; bit rm, ra;
        do_txn(0, 1'b1, 2'b01, 1'b0, 10'h11, 32'h0000FFFF, lat, rd, er, rm, ra);
        n_cmp++; if (er !== 1'b1 || rd !== 32'h0) begin n_bad++; $display("FAIL mis_half_store: got err=%b rdata=%h want err=1 rdata=0", er, rd); end
        do_txn(0, 1'b0, 2'b10, 1'b0, 10'h12, 32'h0, lat, rd, er, rm, ra);
        n_cmp++; if (er !== 1'b1 || rd !== 32'h0) begin n_bad++; $display("FAIL mis_word_load: got err=%b rdata=%h want err=1 rdata=0", er, rd); end
        do_txn(0, 1'b1, 2'b11, 1'b0, 10'h10, 32'h11111111, lat, rd, er, rm, ra);
        n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL rsvd_size: got err=%b want 1", er); end
        do_txn(0, 1'b0, 2'b10, 1'b0, 10'h10, 32'h0, lat, rd, er, rm, ra);
        n_cmp++; if (rd !== 32'hDE5ABEEF || er !== 1'b0) begin n_bad++; $display("FAIL mis_no_write: got %h err=%b want de5abeef err=0", rd, er); end
    endtask

    task automatic test_reset_mid;
        bit er, e_er, seen; bit [31:0] rd, e_rd; int lat; bit rm, ra;
        @(negedge clk);
        req_v[0] = 1'b1; we_v[0] = 1'b1; size_v[0] = 2'b10; sx_v[0] = 1'b0;
        addr_v[0] = 10'h20; wdata_v[0] = 32'h12345678;
        @(posedge clk);
        #1 req_v[0] = 1'b0;
        @(negedge clk);
        n_cmp++; if (ready_v[0] !== 1'b0 || rvalid_v[0] !== 1'b0) begin n_bad++; $display("FAIL mid_wait_state: got ready=%b rvalid=%b want 0 0", ready_v[0], rvalid_v[0]); end
        rst_n = 1'b0;
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (rvalid_v[0] !== 1'b0) seen = 1'b1;
        end
        rst_n = 1'b1;
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL mid_rvalid: got pulse=%b want 0", seen); end
        model_access(0, 1'b0, 2'b10, 1'b0, 'h20, 32'h0, e_er, e_rd);
        do_txn(0, 1'b0, 2'b10, 1'b0, 10'h20, 32'h0, lat, rd, er, rm, ra);
        n_cmp++; if (rd !== e_rd || rd === 32'h12345678) begin n_bad++; $display("FAIL mid_no_commit: got %h want %h", rd, e_rd); end
    endtask

    task automatic test_latency;
        bit er; bit [31:0] rd; int lat; bit rm, ra;
        for (int s = 0; s < 3; s++) begin
            do_txn(s, 1'b0, 2'b10, 1'b0, 10'($urandom_range(0, 255) * 4), 32'h0, lat, rd, er, rm, ra);
            n_cmp++; if (lat !== lat_of(s)) begin n_bad++; $display("FAIL latency[%0d]: got %0d want %0d", s, lat, lat_of(s)); end
            n_cmp++; if (rm !== 1'b0 || ra !== 1'b1) begin n_bad++; $display("FAIL ready_seq[%0d]: got busy=%b idle=%b want 0 1", s, rm, ra); end
        end
    endtask

    task automatic test_back_to_back;
        for (int s = 0; s < 3; s++) begin
            bit [9:0] a; bit e_er; bit [31:0] e_rd; int pulses, last, lat, gap;
            lat = lat_of(s);
            a = 10'($urandom_range(0, 255) * 4);
            model_access(s, 1'b0, 2'b10, 1'b0, int'(a), 32'h0, e_er, e_rd);
            @(negedge clk);
            req_v[s] = 1'b1; we_v[s] = 1'b0; size_v[s] = 2'b10; sx_v[s] = 1'b0; addr_v[s] = a;
            pulses = 0; last = 0;
            for (int k = 1; k <= 4 * (lat + 1) + 4 && pulses < 4; k++) begin
                @(negedge clk);
                if (rvalid_v[s]) begin
                    gap = (pulses == 0) ? lat : lat + 1;
                    n_cmp++; if (k - last != gap) begin n_bad++; $display("FAIL b2b_gap[%0d]: got %0d want %0d", s, k - last, gap); end
                    n_cmp++; if (rdata_v[s] !== e_rd) begin n_bad++; $display("FAIL b2b_rdata[%0d]: got %h want %h", s, rdata_v[s], e_rd); end
                    last = k; pulses++;
                end
            end
            req_v[s] = 1'b0;
            n_cmp++; if (pulses != 4) begin n_bad++; $display("FAIL b2b_pulses[%0d]: got %0d want 4", s, pulses); end
            @(negedge clk);
        end
    endtask

    task automatic test_random;
        for (int s = 0; s < 3; s++)
            for (int i = 0; i < 50; i++) begin
                bit w, sx, er, e_er, rm, ra; bit [1:0] sz; bit [9:0] a; bit [31:0] wd, rd, e_rd; int lat, nb;
                w = 1'($urandom); sx = 1'($urandom); wd = $urandom;
                sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
                nb = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
                a = 10'($urandom_range(0, 63));
                if ($urandom_range(0, 3) != 0) a = a & ~10'(nb - 1);
                model_access(s, w, sz, sx, int'(a), wd, e_er, e_rd);
                do_txn(s, w, sz, sx, a, wd, lat, rd, er, rm, ra);
                n_cmp++;
                if (lat !== lat_of(s) || er !== e_er || rd !== e_rd) begin
                    n_bad++;
                    $display("FAIL rand[%0d.%0d] we=%b sz=%0d a=%h: got lat=%0d err=%b rdata=%h want lat=%0d err=%b rdata=%h",
                             s, i, w, sz, a, lat, er, rd, lat_of(s), e_er, e_rd);
                end
            end
    endtask

    initial begin
        for (int s = 0; s < 3; s++) begin
            req_v[s] = 1'b0; we_v[s] = 1'b0; size_v[s] = 2'b00; sx_v[s] = 1'b0;
            addr_v[s] = 10'h0; wdata_v[s] = 32'h0;
        end
        test_reset();
        preload();
        test_first_txn();
        test_word_byte();
        test_sign_ext();
        test_misalign();
        test_reset_mid();
        test_latency();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end
endmodule
